mc_control_unit: RTL and testbench

- Moore-style multicycle control FSM for the MIPS datapath.
- Sequences the PC, IR, memory, register file, the ALU A-operand mux and the ALU B-operand mux (mux_b_control select) once per instruction.
- Supports R-type, lw, sw, beq, j and addi, with a ready handshake on memory and a watchdog on memory waits.
- Sits beside the datapath top level. Its outputs drive the mux selects and write enables directly.

---
 rtl/mc_control_unit.sv | 217 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: sequences PC, IR, memory, register file and ALU muxes
// once per instruction, with a ready handshake and a watchdog on memory waits.
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mux_a_control,
    output logic [1:0] mux_b_control,
    output logic [1:0] alu_op,
    output logic [3:0] state_out,
    output logic       exc_illegal,
    output logic       mem_fault
);

    // state   | meaning
    // RST     | held in reset, all outputs low
    // FETCH   | read instruction at PC, PC+4 -> PC on ready
    // DECODE  | branch target -> ALUOut, dispatch on opcode
    // EXEC_R  | regA op regB (funct decode)
    // WB_R    | ALUOut -> rd
    // ADDR    | regA + imm for lw/sw
    // MEM_RD  | load data from ALUOut address
    // WB_LW   | MDR -> rt
    // MEM_WR  | store regB at ALUOut address
    // BRANCH  | regA - regB, PC <- ALUOut if zero
    // JUMP    | PC <- jump target
    // EXEC_I  | regA + imm
    // WB_I    | ALUOut -> rt
    // ILLEGAL | halted on unknown opcode
    // FAULT   | halted on memory timeout
    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_WB_R    = 4'd4,
        S_ADDR    = 4'd5,
        S_MEM_RD  = 4'd6,
        S_WB_LW   = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_EXEC_I  = 4'd11,
        S_WB_I    = 4'd12,
        S_ILLEGAL = 4'd13,
        S_FAULT   = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mux_a;
        logic [1:0] mux_b;
        logic [1:0] alu_op;
        logic       exc_illegal;
        logic       mem_fault;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [7:0] WAIT_LOAD = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    ctrl_t      ctrl;

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.mux_b    = 2'b01;
            end
            S_DECODE: c.mux_b = 2'b11;
            S_EXEC_R: begin
                c.mux_a  = 1'b1;
                c.alu_op = 2'b10;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDR, S_EXEC_I: begin
                c.mux_a = 1'b1;
                c.mux_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_WB_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_BRANCH: begin
                c.mux_a         = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_WB_I:    c.reg_write   = 1'b1;
            S_ILLEGAL: c.exc_illegal = 1'b1;
            S_FAULT:   c.mem_fault   = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Watchdog is a down-counter reloaded on every transition; staying in a
    // wait state with no ready at terminal count diverts to FAULT.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = WAIT_LOAD;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)            state_nxt = S_DECODE;
                else if (wait_cnt == '0)  state_nxt = S_FAULT;
                else                      wait_cnt_nxt = wait_cnt - 8'd1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_LW, OP_SW: state_nxt = S_ADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: state_nxt = S_WB_R;
            S_ADDR:   state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)            state_nxt = S_WB_LW;
                else if (wait_cnt == '0)  state_nxt = S_FAULT;
                else                      wait_cnt_nxt = wait_cnt - 8'd1;
            end
            S_MEM_WR: begin
                if (mem_ready)            state_nxt = S_FETCH;
                else if (wait_cnt == '0)  state_nxt = S_FAULT;
                else                      wait_cnt_nxt = wait_cnt - 8'd1;
            end
            S_WB_R, S_WB_LW, S_BRANCH, S_JUMP, S_WB_I: state_nxt = S_FETCH;
            S_EXEC_I:  state_nxt = S_WB_I;
            S_ILLEGAL: state_nxt = S_ILLEGAL;
            S_FAULT:   state_nxt = S_FAULT;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            ctrl     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            ctrl     <= moore_ctrl(state_nxt);
        end
    end

    // IR and PC loads in FETCH follow mem_ready in the same cycle.
    assign ir_write      = (state == S_FETCH) && mem_ready;
    assign pc_write      = ctrl.pc_write | ir_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign mux_a_control = ctrl.mux_a;
    assign mux_b_control = ctrl.mux_b;
    assign alu_op        = ctrl.alu_op;
    assign exc_illegal   = ctrl.exc_illegal;
    assign mem_fault     = ctrl.mem_fault;
    assign state_out     = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed vector table, hand sequences for waits and
// timeouts, then random opcodes/ready checked against an instruction-plan model.
module tb_mc_control_unit;

    localparam int MEM_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, mux_a_control, exc_illegal, mem_fault;
    logic [1:0] pc_source, mux_b_control, alu_op;
    logic [3:0] state_out;
    logic [17:0] dut_ctrl;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mux_a_control(mux_a_control), .mux_b_control(mux_b_control), .alu_op(alu_op),
        .state_out(state_out), .exc_illegal(exc_illegal), .mem_fault(mem_fault)
    );

    assign dut_ctrl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                       ir_write, reg_write, reg_dst, mem_to_reg, mux_a_control,
                       mux_b_control, alu_op, exc_illegal, mem_fault};

    // Control word each state must present, written straight from the state descriptions.
    function automatic logic [17:0] ctrl_of(input int s, input logic rdy);
        logic pw, pwc, io, mr, mw, irw, rw, rd, m2r, ma, ei, mf;
        logic [1:0] psrc, mb, aop;
        {pw, pwc, io, mr, mw, irw, rw, rd, m2r, ma, ei, mf} = '0;
        {psrc, mb, aop} = '0;
        case (s)
            1:  begin mr = 1; mb = 2'b01; pw = rdy; irw = rdy; end
            2:  mb = 2'b11;
            3:  begin ma = 1; aop = 2'b10; end
            4:  begin rw = 1; rd = 1; end
            5:  begin ma = 1; mb = 2'b10; end
            6:  begin mr = 1; io = 1; end
            7:  begin rw = 1; m2r = 1; end
            8:  begin mw = 1; io = 1; end
            9:  begin ma = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            10: begin pw = 1; psrc = 2'b10; end
            11: begin ma = 1; mb = 2'b10; end
            12: rw = 1;
            13: ei = 1;
            14: mf = 1;
            default: ;
        endcase
        return {pw, pwc, psrc, io, mr, mw, irw, rw, rd, m2r, ma, mb, aop, ei, mf};
    endfunction

    task automatic check(input string name, input int exp_state, input logic rdy);
        logic [17:0] e;
        e = ctrl_of(exp_state, rdy);
        n_vec++;
        if (state_out !== 4'(exp_state) || dut_ctrl !== e) begin
            n_bad++;
            $display("FAIL %s: state_out=%0d ctrl=%05h, expected state_out=%0d ctrl=%05h",
                     name, state_out, dut_ctrl, exp_state, e);
        end
    endtask

    task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy,
                       input int exp_state, input string name);
        @(negedge clk);
        reset_n   = rst;
        opcode    = op;
        mem_ready = rdy;
        #1;
        check(name, exp_state, rdy);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        int         st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy, input int st);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cur, waited, term_cycles, stall;
        bit fresh, rst;
        logic rdy;
        logic [5:0] op;
        int rest[$];

        // reset, R-type, sw, beq, j, addi, lw with 3 stall cycles, FETCH stall, reset mid-instruction
        add(0, 6'h00, 1, 0);  add(1, 6'h00, 1, 0);
        add(1, 6'h00, 1, 1);  add(1, 6'h00, 1, 2);  add(1, 6'h00, 1, 3);  add(1, 6'h00, 1, 4);
        add(1, 6'h2B, 1, 1);  add(1, 6'h2B, 1, 2);  add(1, 6'h2B, 1, 5);  add(1, 6'h2B, 1, 8);
        add(1, 6'h04, 1, 1);  add(1, 6'h04, 1, 2);  add(1, 6'h04, 1, 9);
        add(1, 6'h02, 1, 1);  add(1, 6'h02, 1, 2);  add(1, 6'h02, 1, 10);
        add(1, 6'h08, 1, 1);  add(1, 6'h08, 1, 2);  add(1, 6'h08, 1, 11); add(1, 6'h08, 1, 12);
        add(1, 6'h23, 1, 1);  add(1, 6'h23, 1, 2);  add(1, 6'h23, 1, 5);
        add(1, 6'h23, 0, 6);  add(1, 6'h23, 0, 6);  add(1, 6'h23, 0, 6);  add(1, 6'h23, 1, 6);
        add(1, 6'h23, 1, 7);
        add(1, 6'h23, 0, 1);  add(1, 6'h23, 0, 1);  add(1, 6'h23, 1, 1);  add(1, 6'h23, 1, 2);
        add(0, 6'h23, 1, 0);

        foreach (tbl[i]) cyc(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].st, $sformatf("tbl%0d", i));

        // unknown opcode halts and holds until reset
        cyc(1, 6'h3F, 1, 0, "ill_rel");
        cyc(1, 6'h3F, 1, 1, "ill_fetch");
        cyc(1, 6'h3F, 1, 2, "ill_decode");
        for (int k = 0; k < 20; k++) cyc(1, 6'h3F, 1'($urandom_range(0, 1)), 13, "ill_hold");
        cyc(0, 6'h3F, 1, 0, "ill_reset");

        // FETCH waits MEM_TIMEOUT cycles without ready, then faults
        cyc(1, 6'h00, 0, 0, "to_rel");
        for (int k = 0; k < MEM_TIMEOUT; k++) cyc(1, 6'h00, 0, 1, "to_wait");
        for (int k = 0; k < 3; k++) cyc(1, 6'h00, 0, 14, "to_fault");
        cyc(0, 6'h00, 0, 0, "to_reset");

        // ready on the last allowed cycle completes normally
        cyc(1, 6'h00, 0, 0, "edge_rel");
        for (int k = 0; k < MEM_TIMEOUT - 1; k++) cyc(1, 6'h00, 0, 1, "edge_wait");
        cyc(1, 6'h00, 1, 1, "edge_ready");
        cyc(1, 6'h00, 1, 2, "edge_decode");
        cyc(1, 6'h00, 1, 3, "edge_exec");
        cyc(1, 6'h00, 1, 4, "edge_wb");

        // MEM_WR watchdog
        cyc(1, 6'h2B, 1, 1, "sw_fetch");
        cyc(1, 6'h2B, 1, 2, "sw_decode");
        cyc(1, 6'h2B, 1, 5, "sw_addr");
        for (int k = 0; k < MEM_TIMEOUT; k++) cyc(1, 6'h2B, 0, 8, "sw_wait");
        cyc(1, 6'h2B, 0, 14, "sw_fault");
        cyc(0, 6'h2B, 0, 0, "sw_reset");

        // random run against an instruction-plan model
        cur = 0; waited = 0; term_cycles = 0; stall = 0; fresh = 0; op = 6'h00;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (cur >= 13) begin
                term_cycles++;
                rst = (term_cycles < 4);
            end else begin
                term_cycles = 0;
                rst = ($urandom_range(0, 199) != 0);
            end
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if ($urandom_range(0, 99) < 3) begin
                rdy = 1'b0;
                stall = $urandom_range(12, 17);
            end else begin
                rdy = ($urandom_range(0, 99) < 75);
            end
            if (!rst) begin
                cur = 0; waited = 0; rest.delete(); fresh = 0;
            end else if (cur == 1 && fresh) begin
                case ($urandom_range(0, 12))
                    0, 1:   op = 6'h00;
                    2, 3:   op = 6'h23;
                    4, 5:   op = 6'h2B;
                    6, 7:   op = 6'h04;
                    8, 9:   op = 6'h02;
                    10, 11: op = 6'h08;
                    default: begin
                        op = 6'($urandom_range(0, 63));
                        while (is_legal(op)) op = 6'($urandom_range(0, 63));
                    end
                endcase
                case (op)
                    6'h00:   rest = '{2, 3, 4};
                    6'h23:   rest = '{2, 5, 6, 7};
                    6'h2B:   rest = '{2, 5, 8};
                    6'h04:   rest = '{2, 9};
                    6'h02:   rest = '{2, 10};
                    6'h08:   rest = '{2, 11, 12};
                    default: rest = '{2, 13};
                endcase
                fresh = 0;
            end
            reset_n = rst; opcode = op; mem_ready = rdy;
            #1;
            check("rand", cur, rdy);
            if (!rst) begin
                cur = 0;
            end else if (cur == 0) begin
                cur = 1; fresh = 1;
            end else if (cur == 13 || cur == 14) begin
                cur = cur;
            end else if (cur == 1 || cur == 6 || cur == 8) begin
                waited++;
                if (rdy) begin
                    waited = 0;
                    if (rest.size() == 0) begin cur = 1; fresh = 1; end
                    else cur = rest.pop_front();
                end else if (waited == MEM_TIMEOUT) begin
                    waited = 0;
                    cur = 14;
                end
            end else begin
                if (rest.size() == 0) begin cur = 1; fresh = 1; end
                else cur = rest.pop_front();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
